// File: rtl/program_loader.sv
// Byte-stream boot loader: assembles little-endian halfwords from a UART byte
// stream and writes them into program memory, holding the CPU while loading.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MAX_HALFWORDS  = 512,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] byte_address,
  output logic [15:0] write_data,
  output logic        write_enable,
  output logic        new_instruction_write_enable,
  output logic        clear_ram,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned IW = $clog2(MAX_HALFWORDS + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CLEAR   = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_LEN_HI  = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_DATA_HI = 4'd5;
  localparam logic [3:0] S_WRITE   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd8;
  localparam logic [3:0] S_ERROR   = 4'd9;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK     = 4'd7;
`endif

  logic [3:0]    state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic          rx_ready_q, rx_ready_d;
  logic [31:0]   byte_address_q, byte_address_d;
  logic [15:0]   write_data_q, write_data_d;
  logic          write_enable_q, write_enable_d;
  logic          clear_ram_q, clear_ram_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          busy_q, busy_d;
  logic          load_done_q, load_done_d;
  logic          load_error_q, load_error_d;

  logic          accept;
  logic [15:0]   len_rx;
  logic          timed_state;

  assign accept = rx_valid & rx_ready_q;
  assign len_rx = {rx_data, lo_q};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    len_d          = len_q;
    lo_d           = lo_q;
    tmo_d          = '0;
    byte_address_d = byte_address_q;
    write_data_d   = write_data_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d          = xor_q;
`endif
    timed_state    = 1'b0;

    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_ERROR: if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        index_d = '0;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = '0;
`endif
        state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        timed_state = 1'b1;
        if (accept) begin
          len_d = len_rx;
          if (len_rx == 16'd0)                      state_d = S_DONE;
          else if (32'(len_rx) > MAX_HALFWORDS)     state_d = S_ERROR;
          else                                      state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        timed_state = 1'b1;
        if (accept) begin
          lo_d    = rx_data;
`ifdef LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        timed_state = 1'b1;
        if (accept) begin
          write_data_d   = len_rx;
          byte_address_d = 32'(index_q) << 1;
`ifdef LOADER_CHECKSUM_EN
          xor_d          = xor_q ^ rx_data;
`endif
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        index_d = index_q + IW'(1);
        if (32'(index_q) + 32'd1 == 32'(len_q)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA_LO;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        timed_state = 1'b1;
        if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; counter restarts on every accepted byte and state change.
    if (TIMEOUT_CYCLES != 0 && timed_state && !accept && state_d == state_q) begin
      if (32'(tmo_q) + 32'd1 >= TIMEOUT_CYCLES) state_d = S_ERROR;
      else                                      tmo_d   = tmo_q + TW'(1);
    end

    rx_ready_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA_LO) || (state_d == S_DATA_HI)
`ifdef LOADER_CHECKSUM_EN
                     || (state_d == S_CHK)
`endif
                     ;
    write_enable_d = (state_d == S_WRITE);
    clear_ram_d    = (state_d == S_CLEAR);
    busy_d         = (state_d != S_IDLE);
    cpu_hold_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    load_done_d    = (state_d == S_DONE);
    load_error_d   = (state_d == S_ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      index_q        <= '0;
      len_q          <= '0;
      lo_q           <= '0;
      tmo_q          <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
      rx_ready_q     <= 1'b0;
      byte_address_q <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      clear_ram_q    <= 1'b0;
      cpu_hold_q     <= 1'b0;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      len_q          <= len_d;
      lo_q           <= lo_d;
      tmo_q          <= tmo_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
      rx_ready_q     <= rx_ready_d;
      byte_address_q <= byte_address_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
      clear_ram_q    <= clear_ram_d;
      cpu_hold_q     <= cpu_hold_d;
      busy_q         <= busy_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
    end
  end

  assign rx_ready                     = rx_ready_q;
  assign byte_address                 = byte_address_q;
  assign write_data                   = write_data_q;
  assign write_enable                 = write_enable_q;
  assign new_instruction_write_enable = write_enable_q;
  assign clear_ram                    = clear_ram_q;
  assign cpu_hold                     = cpu_hold_q;
  assign busy                         = busy_q;
  assign load_done                    = load_done_q;
  assign load_error                   = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (TIMEOUT_CYCLES = 100).
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] byte_address;
  logic [15:0] write_data;
  logic        write_enable;
  logic        niwe;
  logic        clear_ram;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;

  int          clr_cnt;
  int          done_cnt;
  int          qual_bad;
  logic        done_hold;
  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];

  program_loader #(.MAX_HALFWORDS(512), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .byte_address(byte_address), .write_data(write_data),
    .write_enable(write_enable), .new_instruction_write_enable(niwe),
    .clear_ram(clear_ram), .cpu_hold(cpu_hold), .busy(busy),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Record pulses and writes seen on the memory side.
  always @(negedge clk) begin
    if (clear_ram) clr_cnt++;
    if (load_done) begin
      done_cnt++;
      done_hold = cpu_hold;
    end
    if (write_enable) begin
      wr_addr.push_back(byte_address);
      wr_data.push_back(write_data);
    end
    if (write_enable !== niwe) qual_bad++;
  end

  task automatic clear_logs();
    clr_cnt = 0; done_cnt = 0; qual_bad = 0; done_hold = 1'bx;
    wr_addr.delete(); wr_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte: rx_ready %b required 1 for byte %h", rx_ready, b);
    end
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy %b required 0", busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    outs = {rx_ready, byte_address, write_data, write_enable, niwe,
            clear_ram, cpu_hold, busy, load_done, load_error};
    checks++;
    if (outs !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_logs();
    pulse_start();
    checks++;
    if ({clear_ram, cpu_hold, busy} !== 3'b111) begin
      errors++;
      $display("FAIL basic_clear_hold: clear/hold/busy %b required 111", {clear_ram, cpu_hold, busy});
    end
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    send_byte(8'h93); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h85);
`endif
    wait_idle();
    checks++;
    if (clr_cnt !== 1) begin errors++; $display("FAIL basic_clear_cnt: got %0d required 1", clr_cnt); end
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++; $display("FAIL basic_write_cnt: got %0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 16'h0513) begin
        errors++; $display("FAIL basic_write0: addr %h data %h required 0 0513", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h2 || wr_data[1] !== 16'h0093) begin
        errors++; $display("FAIL basic_write1: addr %h data %h required 2 0093", wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_hold !== 1'b0) begin
      errors++; $display("FAIL basic_done: pulses %0d hold %b required 1 0", done_cnt, done_hold);
    end
    checks++;
    if ({cpu_hold, load_error, qual_bad != 0} !== 3'b000) begin
      errors++; $display("FAIL basic_final: hold %b err %b qual_bad %0d required 0 0 0", cpu_hold, load_error, qual_bad);
    end
    checks++;
    if (byte_address !== 32'h2 || write_data !== 16'h0093) begin
      errors++; $display("FAIL basic_hold_bus: addr %h data %h required 2 0093", byte_address, write_data);
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    checks++;
    if (wr_addr.size() !== 0 || done_cnt !== 1 || load_error !== 1'b0) begin
      errors++; $display("FAIL zero_len: writes %0d done %0d err %b required 0 1 0", wr_addr.size(), done_cnt, load_error);
    end
  endtask

  task automatic test_too_long();
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    repeat (20) @(negedge clk);
    checks++;
    if ({load_error, cpu_hold, busy} !== 3'b111 || wr_addr.size() !== 0 || done_cnt !== 0) begin
      errors++; $display("FAIL too_long_error: err/hold/busy %b writes %0d done %0d required 111 0 0",
                         {load_error, cpu_hold, busy}, wr_addr.size(), done_cnt);
    end
    pulse_start();
    checks++;
    if (load_error !== 1'b0 || clear_ram !== 1'b1) begin
      errors++; $display("FAIL too_long_restart: err %b clear %b required 0 1", load_error, clear_ram);
    end
    send_byte(8'h00); send_byte(8'h02);
    repeat (3) @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL len_max_accept: err %b ready %b required 0 1", load_error, rx_ready);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int k;
    clear_logs();
    pulse_start();
    send_byte(8'h04);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (load_error) begin k = i; break; end
    end
    checks++;
    if (k !== 100) begin
      errors++; $display("FAIL timeout_cycles: got %0d required 100", k);
    end
    pulse_start();
    repeat (150) @(negedge clk);
    checks++;
    if (load_error !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL len_lo_no_timeout: err %b ready %b required 0 1", load_error, rx_ready);
    end
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11);
    repeat (10) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || wr_addr.size() !== 0) begin
      errors++; $display("FAIL data_gap: ready %b writes %0d required 1 0", rx_ready, wr_addr.size());
    end
    send_byte(8'h22);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h33);
`endif
    wait_idle();
    checks++;
    if (wr_addr.size() !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL data_gap_write: writes %0d done %0d required 1 1", wr_addr.size(), done_cnt);
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 16'h2211) begin
        errors++; $display("FAIL data_gap_value: addr %h data %h required 0 2211", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [55:0] outs;
    clear_logs();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (wr_addr.size() == 1) break;
    end
    #2 reset = 1'b1;
    #1;
    outs = {rx_ready, byte_address, write_data, write_enable, niwe,
            clear_ram, cpu_hold, busy, load_done, load_error};
    checks++;
    if (outs !== 56'd0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h required 0", outs);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 1 || clr_cnt !== 1 || done_cnt !== 0) begin
      errors++; $display("FAIL reset_mid_abort: writes %0d clear %0d done %0d required 1 1 0",
                         wr_addr.size(), clr_cnt, done_cnt);
    end
    test_basic();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_logs();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05);
    send_byte(8'h93); send_byte(8'h00);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || done_cnt !== 0) begin
      errors++; $display("FAIL chk_bad: err %b hold %b done %0d required 1 1 0", load_error, cpu_hold, done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_timeout();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
